mm2s_block_reader: RTL

- Drives the datamover MM2S command, status and data-stream interfaces to read back ADC captures from DDR3.
- On `start`, issues `num_blocks` read commands of BTT bytes each, starting at `base_addr`. Each block's address is the previous one plus BTT.
- Read data is forwarded to a downstream AXI-Stream port. Each beat is checked against the incrementing 64-bit pattern the capture side writes.
- Status, framing and pattern errors are reported to the ILA and to control logic.

---
 rtl/mm2s_pkg.sv | 49 ++++
 rtl/mm2s_pattern_check.sv | 29 ++
 rtl/mm2s_block_reader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mm2s_pkg.sv
// Shared types and helpers for the MM2S block reader: the datamover command
// layout, the status bit positions and the FSM state encoding.
package mm2s_pkg;

  localparam logic [22:0] DEF_BTT = 23'h00_1000;
  localparam logic [3:0]  DEF_TAG = 4'hB;

  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_STS,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  tag;
    logic [31:0] saddr;
    logic [7:0]  drr_eof_dsa;
    logic        cmd_type;
    logic [22:0] btt;
  } cmd_t;

  // cmd_type = 1 selects an incrementing burst
  function automatic cmd_t build_cmd(input logic [31:0] addr,
                                     input logic [22:0] btt = DEF_BTT,
                                     input logic [3:0]  tag = DEF_TAG);
    cmd_t c;
    c.rsvd        = 4'b0000;
    c.tag         = tag;
    c.saddr       = addr;
    c.drr_eof_dsa = 8'h00;
    c.cmd_type    = 1'b1;
    c.btt         = btt;
    return c;
  endfunction

  function automatic logic sts_ok(input logic [7:0] sts, input logic [3:0] tag);
    return sts[STS_OKAY] && !sts[STS_SLVERR] && !sts[STS_DECERR] &&
           !sts[STS_INTERR] && (sts[3:0] == tag);
  endfunction

endpackage

// File: rtl/mm2s_pattern_check.sv
// Checks read beats against an incrementing 64-bit pattern; counts mismatches
// with a counter that saturates instead of wrapping.
module mm2s_pattern_check (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        en,
  input  logic [63:0] data,
  output logic [15:0] err_cnt
);

  logic [63:0] expected;

  always_ff @(posedge clk) begin
    if (reset) begin
      expected <= '0;
      err_cnt  <= '0;
    end else if (load) begin
      expected <= seed;
      err_cnt  <= '0;
    end else if (en) begin
      expected <= expected + 64'd1;
      if ((data != expected) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mm2s_block_reader.sv
// Reads num_blocks blocks of BTT bytes through the datamover MM2S interfaces,
// forwards the data stream and reports pattern, framing and status errors.
//
// state | meaning
// IDLE  | waiting for start
// CMD   | presenting the read command for the current block
// DATA  | passing beats through, counting to BEATS
// STS   | consuming the block's status byte
// FIN   | one-cycle done pulse
module mm2s_block_reader
  import mm2s_pkg::*;
#(
  parameter logic [22:0] BTT = DEF_BTT,
  parameter logic [3:0]  TAG = DEF_TAG
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] num_blocks,
  input  logic [63:0] seed,
  output logic        busy,
  output logic        done,
  output logic [71:0] S_AXIS_MM2S_CMD_tdata,
  output logic        S_AXIS_MM2S_CMD_tvalid,
  input  logic        S_AXIS_MM2S_CMD_tready,
  input  logic [7:0]  M_AXIS_MM2S_STS_tdata,
  input  logic        M_AXIS_MM2S_STS_tvalid,
  output logic        M_AXIS_MM2S_STS_tready,
  input  logic [63:0] M_AXIS_MM2S_tdata,
  input  logic [7:0]  M_AXIS_MM2S_tkeep,
  input  logic        M_AXIS_MM2S_tlast,
  input  logic        M_AXIS_MM2S_tvalid,
  output logic        M_AXIS_MM2S_tready,
  output logic [63:0] out_tdata,
  output logic        out_tlast,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [15:0] blocks_done,
  output logic [15:0] data_err_cnt,
  output logic        frame_err,
  output logic        sts_err,
  output logic [7:0]  last_sts
);

  localparam int BEATS  = int'(BTT >> 3);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t state, state_nxt;

  logic [31:0]       addr;
  logic [15:0]       num;
  logic [BEAT_W-1:0] beat;

  logic start_acc, cmd_acc, beat_acc, sts_acc;
  logic last_beat, last_block, sts_good, more_blocks;

  assign start_acc   = start && (state == ST_IDLE);
  assign cmd_acc     = (state == ST_CMD) && S_AXIS_MM2S_CMD_tready;
  assign beat_acc    = (state == ST_DATA) && M_AXIS_MM2S_tvalid && M_AXIS_MM2S_tready;
  assign sts_acc     = (state == ST_STS) && M_AXIS_MM2S_STS_tvalid;
  assign last_beat   = (beat == LAST_BEAT);
  assign last_block  = ({1'b0, blocks_done} + 17'd1) == {1'b0, num};
  assign sts_good    = sts_ok(M_AXIS_MM2S_STS_tdata, TAG);
  // blocks_done has not yet counted the block whose status is being consumed
  assign more_blocks = ({1'b0, blocks_done} + 17'd1) < {1'b0, num};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)    state_nxt = (num_blocks == 16'd0) ? ST_FIN : ST_CMD;
      ST_CMD:  if (cmd_acc)  state_nxt = ST_DATA;
      ST_DATA: if (beat_acc && last_beat) state_nxt = ST_STS;
      ST_STS:  if (sts_acc)  state_nxt = (sts_good && more_blocks) ? ST_CMD : ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy                   = 1'b0;
    done                   = 1'b0;
    S_AXIS_MM2S_CMD_tvalid = 1'b0;
    S_AXIS_MM2S_CMD_tdata  = '0;
    M_AXIS_MM2S_STS_tready = 1'b0;
    M_AXIS_MM2S_tready     = 1'b0;
    out_tvalid             = 1'b0;
    out_tdata              = '0;
    out_tlast              = 1'b0;
    case (state)
      ST_CMD: begin
        busy                   = 1'b1;
        S_AXIS_MM2S_CMD_tvalid = 1'b1;
        S_AXIS_MM2S_CMD_tdata  = build_cmd(addr, BTT, TAG);
      end
      ST_DATA: begin
        busy               = 1'b1;
        M_AXIS_MM2S_tready = out_tready;
        out_tvalid         = M_AXIS_MM2S_tvalid;
        out_tdata          = M_AXIS_MM2S_tdata;
        out_tlast          = last_beat && last_block;
      end
      ST_STS: begin
        busy                   = 1'b1;
        M_AXIS_MM2S_STS_tready = 1'b1;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr        <= '0;
      num         <= '0;
      beat        <= '0;
      blocks_done <= '0;
      frame_err   <= 1'b0;
      sts_err     <= 1'b0;
      last_sts    <= '0;
    end else begin
      if (start_acc) begin
        addr        <= base_addr;
        num         <= num_blocks;
        blocks_done <= '0;
        frame_err   <= 1'b0;
        sts_err     <= 1'b0;
      end
      if (cmd_acc) beat <= '0;
      if (beat_acc) begin
        beat <= beat + 1'b1;
        // block length comes from the beat count; tlast is only checked
        if ((M_AXIS_MM2S_tlast != last_beat) || (M_AXIS_MM2S_tkeep != 8'hFF))
          frame_err <= 1'b1;
      end
      if (sts_acc) begin
        last_sts    <= M_AXIS_MM2S_STS_tdata;
        blocks_done <= blocks_done + 16'd1;
        if (!sts_good)        sts_err <= 1'b1;
        else if (more_blocks) addr    <= addr + 32'(BTT);
      end
    end
  end

  mm2s_pattern_check u_check (
    .clk     (clk),
    .reset   (reset),
    .load    (start_acc),
    .seed    (seed),
    .en      (beat_acc),
    .data    (M_AXIS_MM2S_tdata),
    .err_cnt (data_err_cnt)
  );

endmodule
